// File: rtl/sipo_deserializer_if.sv
// Handshake bundle between a serial beat producer, sipo_deserializer and a word consumer.
// Defining SIPO_FLUSH_EN adds the flush request and the dout_partial flag.
interface sipo_deserializer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
);
    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);

    logic [LANES-1:0]      din;
    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [CNT_W-1:0]      beat_count;
`ifdef SIPO_FLUSH_EN
    logic                  flush;
    logic                  dout_partial;

    modport master (
        output din, din_valid, dout_ready, flush,
        input  din_ready, dout, dout_valid, beat_count, dout_partial
    );

    modport slave (
        input  din, din_valid, dout_ready, flush,
        output din_ready, dout, dout_valid, beat_count, dout_partial
    );
`else
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, beat_count
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, beat_count
    );
`endif
endinterface

// File: rtl/sipo_deserializer.sv
// Multi-lane serial-to-parallel deserializer with valid/ready on both sides and a word holding register.
// Optional SIPO_FLUSH_EN: flush emits a zero-padded partial word flagged by dout_partial.
module sipo_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sipo_deserializer_if.slave   bus
);
    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  dout_valid_q;
    logic                  dout_valid_d;
    logic                  din_ready_s;
    logic                  accept_s;
    logic                  drain_s;
    logic                  last_s;
    logic                  load_s;

    assign din_ready_s = !dout_valid_q || bus.dout_ready;
    assign accept_s    = bus.din_valid && din_ready_s;
    assign drain_s     = dout_valid_q && bus.dout_ready;
    assign last_s      = (cnt_q == CNT_W'(BEATS - 1));

    // The new beat enters at the low end (MSB first) or the high end (LSB first) of the word.
    generate
        if (LANES == DATA_WIDTH) begin : g_full
            logic unused_shreg_s;
            assign unused_shreg_s = ^shreg_q;
            assign shifted_s      = bus.din;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shifted_s = {shreg_q[DATA_WIDTH-LANES-1:0], bus.din};
        end else begin : g_lsb
            assign shifted_s = {bus.din, shreg_q[DATA_WIDTH-1:LANES]};
        end
    endgenerate

`ifdef SIPO_FLUSH_EN
    localparam int SH_W = $clog2(DATA_WIDTH + 1);

    logic                  partial_q;
    logic                  partial_d;
    logic                  flush_act_s;
    logic [CNT_W-1:0]      beats_in_s;
    logic [CNT_W-1:0]      missing_s;
    logic [SH_W-1:0]       pad_shift_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic [DATA_WIDTH-1:0] padded_s;

    // Align a short word as if the missing trailing beats had been zeros.
    always_comb begin
        word_s      = accept_s ? shifted_s : shreg_q;
        beats_in_s  = cnt_q + CNT_W'(accept_s);
        missing_s   = CNT_W'(BEATS) - beats_in_s;
        pad_shift_s = SH_W'(missing_s) * SH_W'(LANES);
        flush_act_s = bus.flush && din_ready_s && ((cnt_q != {CNT_W{1'b0}}) || accept_s);
        if (MSB_FIRST != 0) begin
            padded_s = word_s << pad_shift_s;
        end else begin
            padded_s = word_s >> pad_shift_s;
        end
    end
`endif

    // Next-state for assembly register, beat counter and holding register.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        load_s  = 1'b0;
`ifdef SIPO_FLUSH_EN
        partial_d = partial_q;
`endif
        if (accept_s && last_s) begin
            dout_d  = shifted_s;
            load_s  = 1'b1;
            shreg_d = {DATA_WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
`ifdef SIPO_FLUSH_EN
            partial_d = 1'b0;
`endif
        end
`ifdef SIPO_FLUSH_EN
        else if (flush_act_s) begin
            dout_d    = padded_s;
            load_s    = 1'b1;
            shreg_d   = {DATA_WIDTH{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            partial_d = 1'b1;
        end
`endif
        else if (accept_s) begin
            shreg_d = shifted_s;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // A load in the same cycle as a drain replaces the word without a bubble.
        if (load_s) begin
            dout_valid_d = 1'b1;
        end else if (drain_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q      <= {DATA_WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            dout_q       <= {DATA_WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
`ifdef SIPO_FLUSH_EN
            partial_q    <= 1'b0;
`endif
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef SIPO_FLUSH_EN
            partial_q    <= partial_d;
`endif
        end
    end

    assign bus.din_ready  = din_ready_s;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.beat_count = cnt_q;
`ifdef SIPO_FLUSH_EN
    assign bus.dout_partial = partial_q;
`endif
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: four configurations, scoreboard queues per instance.
// Flush scenarios run only when SIPO_FLUSH_EN is defined.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.DATA_WIDTH(6), .LANES(1)) i6 ();
    sipo_deserializer_if #(.DATA_WIDTH(8), .LANES(2)) ia ();
    sipo_deserializer_if #(.DATA_WIDTH(8), .LANES(2)) ib ();
    sipo_deserializer_if #(.DATA_WIDTH(2), .LANES(2)) iw ();

    sipo_deserializer #(.DATA_WIDTH(6), .LANES(1), .MSB_FIRST(1)) u6 (.clk(clk), .reset(reset), .bus(i6));
    sipo_deserializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1)) ua (.clk(clk), .reset(reset), .bus(ia));
    sipo_deserializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(0)) ub (.clk(clk), .reset(reset), .bus(ib));
    sipo_deserializer #(.DATA_WIDTH(2), .LANES(2), .MSB_FIRST(1)) uw (.clk(clk), .reset(reset), .bus(iw));

    logic p6, pa, pb, pw;
`ifdef SIPO_FLUSH_EN
    assign p6 = i6.dout_partial;
    assign pa = ia.dout_partial;
    assign pb = ib.dout_partial;
    assign pw = iw.dout_partial;
`else
    assign p6 = 1'b0;
    assign pa = 1'b0;
    assign pb = 1'b0;
    assign pw = 1'b0;
`endif

    // Expected {dout_partial, dout} per drained word.
    logic [6:0] q6[$];
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [2:0] qw[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every drained word is popped and compared.
    always @(negedge clk) begin
        if (!reset && i6.dout_valid && i6.dout_ready) begin
            chk("u6_sb_nonempty", 16'(q6.size() != 0), 16'd1);
            if (q6.size() != 0) chk("u6_word", 16'({p6, i6.dout}), 16'(q6.pop_front()));
        end
        if (!reset && ia.dout_valid && ia.dout_ready) begin
            chk("ua_sb_nonempty", 16'(qa.size() != 0), 16'd1);
            if (qa.size() != 0) chk("ua_word", 16'({pa, ia.dout}), 16'(qa.pop_front()));
        end
        if (!reset && ib.dout_valid && ib.dout_ready) begin
            chk("ub_sb_nonempty", 16'(qb.size() != 0), 16'd1);
            if (qb.size() != 0) chk("ub_word", 16'({pb, ib.dout}), 16'(qb.pop_front()));
        end
        if (!reset && iw.dout_valid && iw.dout_ready) begin
            chk("uw_sb_nonempty", 16'(qw.size() != 0), 16'd1);
            if (qw.size() != 0) chk("uw_word", 16'({pw, iw.dout}), 16'(qw.pop_front()));
        end
    end

    task automatic send_6(input logic d);
        int n = 0;
        i6.din = d;
        i6.din_valid = 1'b1;
        @(negedge clk);
        while (!i6.din_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("u6_accept_timeout", 16'(n < 20), 16'd1);
        @(posedge clk);
        #1;
        i6.din_valid = 1'b0;
    endtask

    task automatic send_a(input logic [1:0] d);
        int n = 0;
        ia.din = d;
        ia.din_valid = 1'b1;
        @(negedge clk);
        while (!ia.din_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ua_accept_timeout", 16'(n < 20), 16'd1);
        @(posedge clk);
        #1;
        ia.din_valid = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] d);
        int n = 0;
        ib.din = d;
        ib.din_valid = 1'b1;
        @(negedge clk);
        while (!ib.din_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ub_accept_timeout", 16'(n < 20), 16'd1);
        @(posedge clk);
        #1;
        ib.din_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] w6;
        logic [1:0] wv[3];

        i6.din = 1'b0; i6.din_valid = 1'b0; i6.dout_ready = 1'b1;
        ia.din = 2'b00; ia.din_valid = 1'b0; ia.dout_ready = 1'b1;
        ib.din = 2'b00; ib.din_valid = 1'b0; ib.dout_ready = 1'b1;
        iw.din = 2'b00; iw.din_valid = 1'b0; iw.dout_ready = 1'b1;
`ifdef SIPO_FLUSH_EN
        i6.flush = 1'b0; ia.flush = 1'b0; ib.flush = 1'b0; iw.flush = 1'b0;
`endif
        #1 reset = 1'b1;
        #1;
        chk("rst_dout", 16'(ia.dout), 16'd0);
        chk("rst_dout_valid", 16'(ia.dout_valid), 16'd0);
        chk("rst_beat_count", 16'(ia.beat_count), 16'd0);
        chk("rst_din_ready", 16'(ia.din_ready), 16'd1);
        chk("rst_u6_dout_valid", 16'(i6.dout_valid), 16'd0);
        chk("rst_partial", 16'(pa), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // 6/1/1 bit stream 101100
        w6 = 6'b101100;
        q6.push_back({1'b0, w6});
        for (int k = 0; k < 6; k++) begin
            chk("u6_beat_count", 16'(i6.beat_count), 16'(k));
            send_6(w6[5-k]);
        end
        chk("u6_valid_after_last", 16'(i6.dout_valid), 16'd1);
        chk("u6_count_wrap", 16'(i6.beat_count), 16'd0);
        chk("u6_dout", 16'(i6.dout), 16'h2C);
        @(posedge clk);
        #1;
        chk("u6_valid_one_cycle", 16'(i6.dout_valid), 16'd0);
        chk("u6_dout_kept", 16'(i6.dout), 16'h2C);

        // 8/2 in both bit orders
        qa.push_back({1'b0, 8'hB4});
        send_a(2'b10); send_a(2'b11); send_a(2'b01); send_a(2'b00);
        chk("ua_dout_b4", 16'(ia.dout), 16'hB4);
        qb.push_back({1'b0, 8'h1E});
        send_b(2'b10); send_b(2'b11); send_b(2'b01); send_b(2'b00);
        chk("ub_dout_1e", 16'(ib.dout), 16'h1E);
        @(posedge clk);
        #1;

        // Backpressure: held word stalls the input until dout_ready returns
        ia.dout_ready = 1'b0;
        qa.push_back({1'b0, 8'hB4});
        qa.push_back({1'b0, 8'h1E});
        send_a(2'b10); send_a(2'b11); send_a(2'b01); send_a(2'b00);
        chk("bp_valid", 16'(ia.dout_valid), 16'd1);
        chk("bp_din_ready", 16'(ia.din_ready), 16'd0);
        ia.din = 2'b00;
        ia.din_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_stall_ready", 16'(ia.din_ready), 16'd0);
            chk("bp_stall_count", 16'(ia.beat_count), 16'd0);
            chk("bp_stall_dout", 16'(ia.dout), 16'hB4);
            chk("bp_stall_valid", 16'(ia.dout_valid), 16'd1);
        end
        ia.dout_ready = 1'b1;
        send_a(2'b00);
        chk("bp_resume_count", 16'(ia.beat_count), 16'd1);
        chk("bp_drained", 16'(ia.dout_valid), 16'd0);
        send_a(2'b01); send_a(2'b11); send_a(2'b10);
        chk("bp_word2", 16'(ia.dout), 16'h1E);
        @(posedge clk);
        #1;

        // Reset in the middle of a word
        send_a(2'b01); send_a(2'b10); send_a(2'b11);
        chk("mid_count", 16'(ia.beat_count), 16'd3);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 16'(ia.beat_count), 16'd0);
        chk("mid_rst_dout", 16'(ia.dout), 16'd0);
        chk("mid_rst_valid", 16'(ia.dout_valid), 16'd0);
        chk("mid_rst_ready", 16'(ia.din_ready), 16'd1);
        chk("mid_rst_u6_dout", 16'(i6.dout), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        qa.push_back({1'b0, 8'hFF});
        send_a(2'b11); send_a(2'b11); send_a(2'b11); send_a(2'b11);
        chk("mid_ff", 16'(ia.dout), 16'hFF);
        @(posedge clk);
        #1;

        // Single-beat words: drain and load together keep dout_valid high
        wv[0] = 2'b01; wv[1] = 2'b10; wv[2] = 2'b11;
        for (int k = 0; k < 3; k++) qw.push_back({1'b0, wv[k]});
        iw.din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iw.din = wv[k];
            @(posedge clk);
            #1;
            chk("uw_valid_b2b", 16'(iw.dout_valid), 16'd1);
            chk("uw_dout", 16'(iw.dout), 16'(wv[k]));
        end
        iw.din_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("uw_valid_end", 16'(iw.dout_valid), 16'd0);

`ifdef SIPO_FLUSH_EN
        // Flush after two beats pads with zeros
        qa.push_back({1'b1, 8'hB0});
        send_a(2'b10); send_a(2'b11);
        ia.flush = 1'b1;
        @(posedge clk);
        #1;
        ia.flush = 1'b0;
        chk("fl_valid", 16'(ia.dout_valid), 16'd1);
        chk("fl_partial", 16'(pa), 16'd1);
        chk("fl_dout", 16'(ia.dout), 16'hB0);
        chk("fl_count", 16'(ia.beat_count), 16'd0);
        @(posedge clk);
        #1;
        // Flush with nothing collected is ignored
        ia.flush = 1'b1;
        @(posedge clk);
        #1;
        ia.flush = 1'b0;
        chk("fl_idle_valid", 16'(ia.dout_valid), 16'd0);
        // Flush together with the first beat
        qa.push_back({1'b1, 8'h40});
        ia.flush = 1'b1;
        send_a(2'b01);
        ia.flush = 1'b0;
        chk("fl_one_dout", 16'(ia.dout), 16'h40);
        @(posedge clk);
        #1;
        // Flush on the completing beat is a normal full word
        qa.push_back({1'b0, 8'h6C});
        send_a(2'b01); send_a(2'b10); send_a(2'b11);
        ia.flush = 1'b1;
        send_a(2'b00);
        ia.flush = 1'b0;
        chk("fl_full_partial", 16'(pa), 16'd0);
        chk("fl_full_dout", 16'(ia.dout), 16'h6C);
        // LSB-first flush shifts right
        qb.push_back({1'b1, 8'h0E});
        send_b(2'b10);
        ib.flush = 1'b1;
        send_b(2'b11);
        ib.flush = 1'b0;
        chk("fl_lsb_dout", 16'(ib.dout), 16'h0E);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("u6_sb_empty", 16'(q6.size()), 16'd0);
        chk("ua_sb_empty", 16'(qa.size()), 16'd0);
        chk("ub_sb_empty", 16'(qb.size()), 16'd0);
        chk("uw_sb_empty", 16'(qw.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
